// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit add/subtract, DIGIT bits per clock, LS digit first; result N=WIDTH/DIGIT cycles after start.
// No backpressure: start is taken in IDLE or DONE only, ignored while busy, never queued.
module serial_addsub #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] z,
   output logic             cout,
   output logic             ovf
);
   localparam int N  = WIDTH / DIGIT;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
   logic             carry_q;
   logic [KW-1:0]    k_q;
   logic [DIGIT:0]   dsum;
   logic             last, accept, c_msb;

   assign last   = (k_q == KW'(N - 1));
   assign accept = start && (state != RUN);

   // Operands shift down each cycle, so the current digit always sits in the low bits.
   assign dsum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
   // Carry into the digit MSB recovered from that bit's sum and operands.
   assign c_msb = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

   generate
      if (DIGIT == WIDTH) begin : g_single
         assign acc_nxt = dsum[DIGIT-1:0];
      end else begin : g_multi
         assign acc_nxt = {dsum[DIGIT-1:0], acc_q[WIDTH-1:DIGIT]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
         z       <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= sub ? ~b : b;
         carry_q <= sub ? ~cin : cin;
         k_q     <= '0;
      end else if (state == RUN) begin
         a_q     <= a_q >> DIGIT;
         b_q     <= b_q >> DIGIT;
         carry_q <= dsum[DIGIT];
         acc_q   <= acc_nxt;
         k_q     <= k_q + KW'(1);
         // Visible outputs move only once the whole word is assembled.
         if (last) begin
            z    <= acc_nxt;
            cout <= dsum[DIGIT];
            ovf  <= c_msb ^ dsum[DIGIT];
         end
      end
   end
endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomised checks of serial_addsub at DIGIT = 1, 4 and 16 sharing one stimulus.
module tb_serial_addsub;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, sub, cin;
   logic [15:0] a, b;

   logic        busy1, done1, cout1, ovf1;
   logic        busy4, done4, cout4, ovf4;
   logic        busy16, done16, cout16, ovf16;
   logic [15:0] z1, z4, z16;

   int nvec  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(16), .DIGIT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
      .busy(busy1), .done(done1), .z(z1), .cout(cout1), .ovf(ovf1));
   serial_addsub #(.WIDTH(16), .DIGIT(4)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
      .busy(busy4), .done(done4), .z(z4), .cout(cout4), .ovf(ovf4));
   serial_addsub #(.WIDTH(16), .DIGIT(16)) u16 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
      .busy(busy16), .done(done16), .z(z16), .cout(cout16), .ovf(ovf16));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Returns {ovf, cout, z}
   function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic ms, input logic mc);
      logic [15:0] bp;
      logic [16:0] s;
      logic        c0, ov;
      bp = ms ? ~mb : mb;
      c0 = ms ? ~mc : mc;
      s  = {1'b0, ma} + {1'b0, bp} + {16'b0, c0};
      ov = (ma[15] == bp[15]) && (s[15] != ma[15]);
      return {ov, s};
   endfunction

   // Called at a falling edge; returns at the falling edge after the accepting edge.
   task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic ts, input logic tc);
      a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done4(output int lat);
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         if (done4) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run4(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic ts, input logic tc,
                       input logic [15:0] ez, input logic ec, input logic eo);
      int lat;
      issue(ta, tb_, ts, tc);
      wait_done4(lat);
      chk({tag, "_lat"}, lat, 4);
      chk({tag, "_z"}, z4, ez);
      chk({tag, "_cout"}, cout4, ec);
      chk({tag, "_ovf"}, ovf4, eo);
      @(negedge clk);
   endtask

   task automatic regress(input logic [15:0] ra, input logic [15:0] rb, input logic rs, input logic rc);
      logic [17:0] exp, r1, r4, r16;
      int l1, l4, l16;
      exp = model(ra, rb, rs, rc);
      l1 = -1; l4 = -1; l16 = -1;
      r1 = '0; r4 = '0; r16 = '0;
      issue(ra, rb, rs, rc);
      for (int i = 0; i < 24; i++) begin
         if (done1 && l1 < 0)   begin l1 = i;  r1 = {ovf1, cout1, z1};    end
         if (done4 && l4 < 0)   begin l4 = i;  r4 = {ovf4, cout4, z4};    end
         if (done16 && l16 < 0) begin l16 = i; r16 = {ovf16, cout16, z16}; end
         @(negedge clk);
      end
      chk("rg_lat_d1", l1, 16);
      chk("rg_lat_d4", l4, 4);
      chk("rg_lat_d16", l16, 1);
      chk("rg_res_d1", r1, exp);
      chk("rg_res_d4", r4, exp);
      chk("rg_res_d16", r16, exp);
   endtask

   initial begin
      logic seen;
      // Reset held with random inputs and start asserted: reset wins
      rst_n = 1'b0;
      start = 1'b1;
      sub   = 1'($urandom);
      cin   = 1'($urandom);
      a     = 16'($urandom);
      b     = 16'($urandom);
      #32;
      chk("rst_z", z4, 16'h0000);
      chk("rst_cout", cout4, 1'b0);
      chk("rst_ovf", ovf4, 1'b0);
      chk("rst_busy", busy4, 1'b0);
      chk("rst_done", done4, 1'b0);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_z", z4, 16'h0000);
      chk("post_rst_busy", busy4, 1'b0);
      chk("post_rst_done", done4, 1'b0);

      run4("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run4("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run4("add_cin",  16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
      run4("sub_neg",  16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      run4("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      run4("sub_bin",  16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);

      // Start during busy is ignored; start in the done cycle is accepted
      issue(16'h1234, 16'h1111, 1'b0, 1'b0);
      @(negedge clk);
      chk("hs_busy", busy4, 1'b1);
      a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("hs_no_early_done", done4, 1'b0);
      @(negedge clk);
      chk("hs_done1", done4, 1'b1);
      chk("hs_z1", z4, 16'h2345);
      issue(16'h0100, 16'h0001, 1'b1, 1'b0);
      chk("hs_done_single", done4, 1'b0);
      chk("hs_busy2", busy4, 1'b1);
      chk("hs_hold0", z4, 16'h2345);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk("hs_hold", z4, 16'h2345);
      end
      @(negedge clk);
      chk("hs_done2", done4, 1'b1);
      chk("hs_z2", z4, 16'h00FF);
      chk("hs_cout2", cout4, 1'b1);
      chk("hs_ovf2", ovf4, 1'b0);
      repeat (2) @(negedge clk);

      // Abort mid-run: outputs clear at once, no done follows
      issue(16'h00AA, 16'h0011, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_z", z4, 16'h0000);
      chk("abort_cout", cout4, 1'b0);
      chk("abort_busy", busy4, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (done4) seen = 1'b1;
         @(negedge clk);
      end
      chk("abort_no_done", seen, 1'b0);

      // Regression across three digit widths
      repeat (20) @(negedge clk);
      regress(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      regress(16'h8000, 16'h0001, 1'b1, 1'b0);
      regress(16'h8000, 16'h8000, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         regress(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle adder/subtractor: it computes a WIDTH-bit sum or difference DIGIT bits per clock, least-significant digit first. It is the sequential successor of the team's 4-bit ripple-carry full-adder chain, adding subtraction, carry-in, signed overflow and a start/done handshake. Narrow DIGIT values trade latency for a short carry chain, so the block can share a fast clock domain with the rest of the datapath.

## Interface
- WIDTH, 16, operand and result width in bits.
- DIGIT, 4, bits processed per cycle. 1 ≤ DIGIT ≤ WIDTH, and WIDTH % DIGIT == 0. N = WIDTH/DIGIT.
- Clk  in  1  clock; all state changes on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE or DONE.
- Sub  in  1  0 = add, 1 = subtract; sampled with Start.
- Cin  in  1  carry-in (add) or borrow-in (sub); sampled with Start.
- A  in  WIDTH  operand A; sampled with Start.
- B  in  WIDTH  operand B; sampled with Start.
- Busy  out  1  high while in RUN.
- Done  out  1  one-cycle pulse; result outputs valid and updated.
- Z  out  WIDTH  result, registered.
- Cout  out  1  carry out of the MSB. For subtract this is NOT-borrow.
- Ovf  out  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Transitions:
  - IDLE → RUN when Start = 1.
  - RUN → RUN while the digit counter k < N−1.
  - RUN → DONE after digit N−1 completes.
  - DONE → RUN when Start = 1; otherwise DONE → IDLE.
- On accept, the block latches A, B' = Sub ? ~B : B, and the initial carry c0 = Sub ? ~Cin : Cin, then clears k to 0.
- Arithmetic:
  - Add: Z = A + B + Cin.
  - Sub: Z = A − B − Cin, computed as A + ~B + ~Cin.
- Each RUN cycle:
  - Computes digit k = A[kD+:D] + B'[kD+:D] + carry.
  - Writes the digit into the internal result shift register.
  - Stores the digit carry-out as the next carry.
  - Increments k.
- Ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1. The carry into the MSB is tapped inside the final digit.
- Z, Cout and Ovf update together, only on the RUN → DONE edge. They hold their values until the next RUN → DONE edge and never show partial results.
- Start, A, B, Sub and Cin are ignored while in RUN. A request is never queued.
- Reset mid-operation: the operation is aborted, the FSM goes to IDLE, and no Done is produced.

## Timing
- Reset values: Busy = 0, Done = 0, Z = 0, Cout = 0, Ovf = 0, k = 0, FSM = IDLE.
- The reset assertion affects outputs immediately (asynchronous). The reset release is synchronous to the next Clk edge.
- With Start sampled at edge e0:
  - Busy is high during cycles e0..e(N−1).
  - Done is high for exactly one cycle after edge eN.
  - Latency is N cycles from Start to Done.
- DIGIT == WIDTH (N = 1): Busy is high for one cycle and Done follows one cycle after Start.
- Back-to-back requests: a Start sampled in the DONE cycle is accepted, so sustained throughput is one result per N+1 cycles. Busy rises the cycle after Done.
- Simultaneous Start and reset: reset wins.
- Done is never asserted in consecutive cycles.

## Test plan
- Reset: hold Rst_n = 0 with random inputs → Z = 0x0000, Cout = 0, Ovf = 0, Busy = 0, Done = 0. After release with Start = 0 → outputs stay 0.
- Add carry wrap (WIDTH = 16, DIGIT = 4): A = 0xFFFF, B = 0x0001, Cin = 0, Sub = 0 → Done exactly 4 cycles after Start, Z = 0x0000, Cout = 1, Ovf = 0.
- Signed overflow:
  - 0x7FFF + 0x0001, Cin = 0 → Z = 0x8000, Cout = 0, Ovf = 1.
  - 0x0000 + 0x0000, Cin = 1 → Z = 0x0001, Ovf = 0.
- Subtract:
  - 0x0003 − 0x0005, Cin = 0 → Z = 0xFFFE, Cout = 0, Ovf = 0.
  - 0x8000 − 0x0001 → Z = 0x7FFF, Cout = 1, Ovf = 1.
  - 0x0005 − 0x0003, Cin = 1 → Z = 0x0001, Cout = 1.
- Handshake:
  - Start pulsed during Busy with different operands → ignored; the first result is unchanged.
  - Start asserted in the Done cycle → second Done exactly 4 cycles later with the correct result.
  - Z stays stable between the two Done pulses.
- Abort and regression:
  - Rst_n pulsed low mid-RUN → outputs are 0 immediately and no Done follows.
  - Random operands, Sub and Cin checked against a behavioural model for DIGIT = 1, 4 and 16 → Z, Cout and Ovf match, and latency equals WIDTH/DIGIT.
